// File: rtl/rr_mux_4_1_arbiter.sv
// Round-robin arbiter that time-multiplexes four valid/ready requesters onto one
// registered output slot. The slot refills on the same edge it drains.
module rr_mux_4_1_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [3:0]       req_valid,
  output logic [3:0]       req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [1:0]       out_sel_q,   out_sel_d;
  logic [1:0]       last_grant_q, last_grant_d;

  logic             load;
  logic             found;
  logic             grant;
  logic [1:0]       winner;
  logic [1:0]       cand;
  logic [WIDTH-1:0] mux_data;

  // The slot may take a new word when it is empty or being drained this cycle.
  assign load  = !out_valid_q || out_ready;
  assign grant = load && found && !rst;

  // Search starts one past the last winner, so the previous winner has lowest priority.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    found  = 1'b0;
    winner = 2'd0;
    cand   = last_grant_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_q + k[1:0];
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Only the selected word reaches the register, so unknowns on other inputs stay out.
  always_comb begin
    case (winner)
      2'd0:    mux_data = d0;
      2'd1:    mux_data = d1;
      2'd2:    mux_data = d2;
      default: mux_data = d3;
    endcase
  end

  always_comb begin
    req_ready = 4'b0000;
    if (grant) req_ready[winner] = 1'b1;
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    last_grant_d = last_grant_q;
    if (grant) begin
      out_valid_d  = 1'b1;
      out_data_d   = mux_data;
      out_sel_d    = winner;
      last_grant_d = winner;
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= 2'd0;
      last_grant_q <= 2'd3;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
